nbit_pipe_addsub: RTL and testbench

//   Parametrised, pipelined N-bit adder/subtractor. Successor to the single-register N-bit adder.
//   The carry chain is split into STAGES equal chunks, with one register stage per chunk.

---
 rtl/nbit_pipe_addsub_pkg.sv | 25 ++
 rtl/nbit_pipe_addsub_if.sv | 26 ++
 rtl/nbit_pipe_addsub_chunk.sv | 33 +++
 rtl/nbit_pipe_addsub.sv | 118 +++++++++++
 tb/tb_nbit_pipe_addsub.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/nbit_pipe_addsub_pkg.sv
// Shared opcodes and the signed saturation constant for the pipelined adder/subtractor.
package addsub_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam logic [1:0] OP_ADD_SAT = 2'b10;
    localparam logic [1:0] OP_SUB_SAT = 2'b11;

    localparam int MAX_N = 64;

    // sign=1 gives the most negative n-bit value, sign=0 the most positive.
    function automatic logic [MAX_N-1:0] sat_val(input int n, input logic sign);
        logic [MAX_N-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i == n - 1) begin
                v[i] = sign;
            end else if (i < n - 1) begin
                v[i] = ~sign;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/nbit_pipe_addsub_if.sv
// Operand/result stream bundle between the register file, the adder and writeback.
interface nbit_pipe_addsub_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         c_out;
    logic         ovf;

    modport master (
        output in_valid, a, b, c_in, op, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, op, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/nbit_pipe_addsub_chunk.sv
// One W-bit slice of the carry chain with its stage register (sum chunk, carry, valid).
module nbit_pipe_chunk #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         adv,
    input  logic         prev_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         prev_carry,
    output logic         valid,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, prev_carry};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (adv) begin
            valid <= prev_valid;
            sum   <= total[W-1:0];
            carry <= total[W];
        end
    end

endmodule

// File: rtl/nbit_pipe_addsub.sv
// Pipelined N-bit add/sub: STAGES carry-chain chunks, skewed operands, overflow/saturation
// at the last stage, and a stall-everything valid/ready handshake.
module nbit_pipe_addsub
    import addsub_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input logic               clk,
    input logic               rst_n,
    nbit_pipe_addsub_if.slave bus
);

    localparam int W = N / STAGES;

    if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
        $error("nbit_pipe_addsub: N must be a multiple of STAGES with 1 <= STAGES <= N");
    end

    logic                       adv;
    logic                       sub_op;
    logic                       sat_op;
    logic [N-1:0]               b_eff;
    logic [STAGES-1:0][N-1:0]   a_q;
    logic [STAGES-1:0][N-1:0]   b_q;
    logic [STAGES-1:0][N-1:0]   lo_q;
    logic [STAGES-1:0][N-1:0]   part;
    logic [STAGES-1:0]          sat_q;
    logic [STAGES-1:0]          valid_s;
    logic [STAGES-1:0]          carry_s;
    logic [STAGES-1:0][W-1:0]   sum_s;
    logic [N-1:0]               raw;
    logic                       a_msb;
    logic                       b_msb;
    logic                       ovf;
    logic [MAX_N-1:0]           sat_word;
    logic                       unused_bits;

    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    assign sub_op = (bus.op == OP_SUB) || (bus.op == OP_SUB_SAT);
    assign sat_op = (bus.op == OP_ADD_SAT) || (bus.op == OP_SUB_SAT);
    assign b_eff  = sub_op ? ~bus.b : bus.b;

    // Operands ride along so chunk k sees its slice one stage after chunk k-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            lo_q  <= '0;
            sat_q <= '0;
        end else if (adv) begin
            a_q[0]   <= bus.a;
            b_q[0]   <= b_eff;
            sat_q[0] <= sat_op;
            for (int k = 1; k < STAGES; k++) begin
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                sat_q[k] <= sat_q[k-1];
                lo_q[k]  <= part[k-1];
            end
        end
    end

    always_comb begin
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            part[k]            = lo_q[k];
            part[k][k*W +: W]  = sum_s[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            nbit_pipe_chunk #(.W(W)) u_chunk (
                .clk        (clk),
                .rst_n      (rst_n),
                .adv        (adv),
                .prev_valid (bus.in_valid),
                .a          (bus.a[W-1:0]),
                .b          (b_eff[W-1:0]),
                .prev_carry (bus.c_in),
                .valid      (valid_s[k]),
                .sum        (sum_s[k]),
                .carry      (carry_s[k])
            );
        end else begin : g_next
            nbit_pipe_chunk #(.W(W)) u_chunk (
                .clk        (clk),
                .rst_n      (rst_n),
                .adv        (adv),
                .prev_valid (valid_s[k-1]),
                .a          (a_q[k-1][k*W +: W]),
                .b          (b_q[k-1][k*W +: W]),
                .prev_carry (carry_s[k-1]),
                .valid      (valid_s[k]),
                .sum        (sum_s[k]),
                .carry      (carry_s[k])
            );
        end
    end

    assign raw      = part[STAGES-1];
    assign a_msb    = a_q[STAGES-1][N-1];
    assign b_msb    = b_q[STAGES-1][N-1];
    assign ovf      = (a_msb == b_msb) && (raw[N-1] != a_msb);
    assign sat_word = sat_val(N, a_msb);

    assign bus.out_valid = valid_s[STAGES-1];
    assign bus.c_out     = carry_s[STAGES-1];
    assign bus.ovf       = ovf;
    assign bus.sum       = (sat_q[STAGES-1] && ovf) ? sat_word[N-1:0] : raw;

    // Operand words are kept whole per stage; only some slices feed logic downstream.
    assign unused_bits = ^{a_q, b_q, lo_q[0], sat_word};

endmodule

// File: tb/tb_nbit_pipe_addsub.sv
// Bench: four instances (STAGES=1,2,4,8) share one stimulus stream; each is checked
// every cycle against a queue-based model, plus literal expectations for directed vectors.
module tb_nbit_pipe_addsub;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         age;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic [1:0] op;
    logic       out_ready;

    logic [3:0] ov;
    logic [3:0] ir;
    logic [7:0] sm [4];
    logic [3:0] co;
    logic [3:0] of;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int inst, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h t=%0t", nm, inst, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv_in,
                                   input logic cin, input logic [1:0] opv);
        exp_t e;
        int   bv, t, sa, sb, st;
        bv  = opv[0] ? 255 - int'(bv_in) : int'(bv_in);
        t   = int'(av) + bv + int'(cin);
        e.s = 8'(t % 256);
        e.c = (t >= 256);
        sa  = (av >= 8'd128) ? int'(av) - 256 : int'(av);
        sb  = (bv >= 128) ? bv - 256 : bv;
        st  = sa + sb + int'(cin);
        e.o = (st > 127) || (st < -128);
        if (opv[1] && e.o) e.s = (sa < 0) ? 8'h80 : 8'h7F;
        e.age = 0;
        return e;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int S = 1 << gi;

        nbit_pipe_addsub_if #(.N(8)) bus ();

        assign bus.in_valid  = in_valid;
        assign bus.a         = a;
        assign bus.b         = b;
        assign bus.c_in      = c_in;
        assign bus.op        = op;
        assign bus.out_ready = out_ready;

        nbit_pipe_addsub #(.N(8), .STAGES(S)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );

        assign ov[gi] = bus.out_valid;
        assign ir[gi] = bus.in_ready;
        assign sm[gi] = bus.sum;
        assign co[gi] = bus.c_out;
        assign of[gi] = bus.ovf;

        exp_t q[$];
        int   pop_cnt = 0;

        always @(posedge clk or negedge rst_n) begin
            logic expv, adv;
            exp_t e;
            if (!rst_n) begin
                q.delete();
            end else begin
                expv = (q.size() > 0) && (q[0].age == S);
                adv  = !expv || out_ready;
                if (expv && out_ready) begin
                    void'(q.pop_front());
                    pop_cnt++;
                end
                if (adv) begin
                    foreach (q[j]) q[j].age++;
                    if (in_valid) begin
                        e     = model(a, b, c_in, op);
                        e.age = 1;
                        q.push_back(e);
                    end
                end
            end
        end

        always @(negedge clk) begin
            logic expv;
            expv = (q.size() > 0) && (q[0].age == S);
            check("out_valid", gi, 16'(ov[gi]), 16'(expv));
            check("in_ready", gi, 16'(ir[gi]), 16'(!expv || out_ready));
            if (expv) begin
                check("sum", gi, 16'(sm[gi]), 16'(q[0].s));
                check("c_out", gi, 16'(co[gi]), 16'(q[0].c));
                check("ovf", gi, 16'(of[gi]), 16'(q[0].o));
            end
        end
    end

    // Drives one beat at posedge+1 phase and checks literal results/latency on every instance.
    task automatic run_one(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           input logic [1:0] opv, input logic [7:0] xs, input logic xc,
                           input logic xo);
        logic [3:0] seen;
        seen      = '0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = av; b = bv; c_in = cv; op = opv;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < 4; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i] = 1'b1;
                    check("lit_latency", i, 16'(cyc), 16'(1 << i));
                    check("lit_sum", i, 16'(sm[i]), 16'(xs));
                    check("lit_c_out", i, 16'(co[i]), 16'(xc));
                    check("lit_ovf", i, 16'(of[i]), 16'(xo));
                end
            end
        end
        for (int i = 0; i < 4; i++) check("lit_seen", i, 16'(seen[i]), 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, stalls, pops0;
        logic r;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op = 2'b00; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 1, 16'(ov[1]), 16'd0);
        check("rst_in_ready", 1, 16'(ir[1]), 16'd1);
        check("rst_sum", 1, 16'(sm[1]), 16'h00);
        check("rst_c_out", 1, 16'(co[1]), 16'd0);
        check("rst_ovf", 1, 16'(of[1]), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one(8'h0F, 8'h01, 1'b0, 2'b00, 8'h10, 1'b0, 1'b0);
        run_one(8'hFF, 8'h01, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        run_one(8'h7F, 8'h01, 1'b0, 2'b00, 8'h80, 1'b0, 1'b1);
        run_one(8'h7F, 8'h01, 1'b0, 2'b10, 8'h7F, 1'b0, 1'b1);
        run_one(8'h00, 8'h01, 1'b1, 2'b01, 8'hFF, 1'b0, 1'b0);
        run_one(8'h80, 8'h01, 1'b1, 2'b11, 8'h80, 1'b1, 1'b1);
        run_one(8'h05, 8'h03, 1'b1, 2'b01, 8'h02, 1'b1, 1'b0);
        run_one(8'h01, 8'h01, 1'b1, 2'b00, 8'h03, 1'b0, 1'b0);

        // Back-to-back stream with a 3-cycle downstream stall.
        sent   = 0;
        stalls = 0;
        pops0  = g_dut[1].pop_cnt;
        for (int cyc = 0; cyc < 50 && sent < 6; cyc++) begin
            out_ready = !(cyc >= 3 && cyc < 6);
            in_valid  = 1'b1;
            a    = 8'(sent * 37);
            b    = 8'(8'h31 + sent);
            c_in = 1'(sent % 2);
            op   = 2'(sent % 4);
            @(negedge clk);
            r = ir[1];
            if (!r) stalls++;
            @(posedge clk);
            #1;
            if (r) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("stream_sent", 1, 16'(sent), 16'd6);
        check("stream_stalls", 1, 16'(stalls), 16'd3);
        check("stream_pops", 1, 16'(g_dut[1].pop_cnt - pops0), 16'd6);

        // Async reset with two beats in flight.
        in_valid = 1'b1; a = 8'h11; b = 8'h22; c_in = 1'b0; op = 2'b00;
        @(posedge clk);
        #1 a = 8'h33; b = 8'h44;
        @(posedge clk);
        #1 check("pre_rst_valid", 1, 16'(ov[1]), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 1, 16'(ov[1]), 16'd0);
        check("async_rst_ready", 1, 16'(ir[1]), 16'd1);
        check("async_rst_sum", 1, 16'(sm[1]), 16'h00);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_ready", 1, 16'(ir[1]), 16'd1);
        repeat (10) @(posedge clk);
        #1 check("no_stale_pops", 1, 16'(g_dut[1].q.size()), 16'd0);
        run_one(8'h20, 8'h05, 1'b0, 2'b00, 8'h25, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
